uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 33 +++
 rtl/slib_edge_detect.sv | 25 ++
 rtl/uart_rx_core.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e   : receiver FSM states
//   Wls*         : word-length select encodings
//   last_bit_idx : index of the final data bit for a given word length
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop,
    StMwait
  } rx_state_e;

  localparam logic [1:0] Wls5 = 2'b00;
  localparam logic [1:0] Wls6 = 2'b01;
  localparam logic [1:0] Wls7 = 2'b10;
  localparam logic [1:0] Wls8 = 2'b11;

  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    logic [2:0] idx;
    unique case (wls)
      Wls5:    idx = 3'd4;
      Wls6:    idx = 3'd5;
      Wls7:    idx = 3'd6;
      Wls8:    idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/slib_edge_detect.sv
// Falling-edge detector for a synchronous single-bit signal.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (history cleared to 0)
//   d_i    : monitored signal
//   fe_o   : high while d_i is 0 and it was 1 in the previous cycle
module slib_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic fe_o
);

  logic hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= d_i;
    end
  end

  assign fe_o = hist_q & ~d_i;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled start/data/parity/stop framing.
//   CLK, RST    : clock, asynchronous active-high reset
//   RXCLK       : 16x baud tick enable
//   CLEAR       : synchronous abort back to idle
//   WLS/PEN/EPS/SP : frame format, captured at the start edge
//   SIN         : serial input (idle high)
//   DOUT        : last received word, LSB first, upper bits zero
//   PE/FE/BI    : parity error, framing error, break for the last frame
//   RXFINISHED  : one-cycle pulse when a frame completes
module uart_rx_core
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       SIN,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_q, data_d;
  logic       par_bit_q, par_bit_d;
  logic [1:0] wls_q, wls_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       sp_q, sp_d;
  logic [7:0] dout_q, dout_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       bi_q, bi_d;
  logic       rx_finished_q, rx_finished_d;

  logic       sin_fall;
  logic       mid_tick;
  logic       exp_par;

  slib_edge_detect u_sin_edge (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (SIN),
    .fe_o  (sin_fall)
  );

  // Counter wraps in the middle of each bit once aligned by the start-bit check.
  assign mid_tick = RXCLK && (cnt_q == 4'd15);
  assign exp_par  = sp_q ? ~eps_q : ((^data_q) ^ ~eps_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    data_d        = data_q;
    par_bit_d     = par_bit_q;
    wls_d         = wls_q;
    pen_d         = pen_q;
    eps_d         = eps_q;
    sp_d          = sp_q;
    dout_d        = dout_q;
    pe_d          = pe_q;
    fe_d          = fe_q;
    bi_d          = bi_q;
    rx_finished_d = 1'b0;

    if (CLEAR) begin
      state_d   = StIdle;
      cnt_d     = 4'd0;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Edge detection is not gated by RXCLK.
          if (sin_fall) begin
            state_d   = StStart;
            cnt_d     = 4'd0;
            bit_cnt_d = 3'd0;
            data_d    = 8'h00;
            par_bit_d = 1'b0;
            wls_d     = WLS;
            pen_d     = PEN;
            eps_d     = EPS;
            sp_d      = SP;
          end
        end
        StStart: begin
          if (RXCLK) begin
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              state_d = SIN ? StIdle : StData;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        StData: begin
          if (RXCLK) begin
            cnt_d = cnt_q + 4'd1;
            if (mid_tick) begin
              data_d[bit_cnt_q] = SIN;
              if (bit_cnt_q == last_bit_idx(wls_q)) begin
                bit_cnt_d = 3'd0;
                state_d   = pen_q ? StPar : StStop;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
          end
        end
        StPar: begin
          if (RXCLK) begin
            cnt_d = cnt_q + 4'd1;
            if (mid_tick) begin
              par_bit_d = SIN;
              state_d   = StStop;
            end
          end
        end
        StStop: begin
          if (RXCLK) begin
            cnt_d = cnt_q + 4'd1;
            if (mid_tick) begin
              state_d       = StMwait;
              rx_finished_d = 1'b1;
              dout_d        = data_q;
              pe_d          = pen_q & (par_bit_q != exp_par);
              fe_d          = ~SIN;
              // par_bit_q stays 0 when parity is disabled.
              bi_d          = (data_q == 8'h00) & ~par_bit_q & ~SIN;
            end
          end
        end
        StMwait: begin
          // Hold here through a break so it yields a single frame.
          if (RXCLK && SIN) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      bit_cnt_q     <= 3'd0;
      data_q        <= 8'h00;
      par_bit_q     <= 1'b0;
      wls_q         <= Wls8;
      pen_q         <= 1'b0;
      eps_q         <= 1'b0;
      sp_q          <= 1'b0;
      dout_q        <= 8'h00;
      pe_q          <= 1'b0;
      fe_q          <= 1'b0;
      bi_q          <= 1'b0;
      rx_finished_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      par_bit_q     <= par_bit_d;
      wls_q         <= wls_d;
      pen_q         <= pen_d;
      eps_q         <= eps_d;
      sp_q          <= sp_d;
      dout_q        <= dout_d;
      pe_q          <= pe_d;
      fe_q          <= fe_d;
      bi_q          <= bi_d;
      rx_finished_q <= rx_finished_d;
    end
  end

  assign DOUT       = dout_q;
  assign PE         = pe_q;
  assign FE         = fe_q;
  assign BI         = bi_q;
  assign RXFINISHED = rx_finished_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core; one RXCLK tick per CLK cycle.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RXCLK;
  logic       CLEAR;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic       SP;
  logic       SIN;
  logic [7:0] DOUT;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       RXFINISHED;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fin_cnt  = 0;
  int fin_cyc  = 0;
  int start_cyc = 0;
  int fin_base = 0;

  uart_rx_core dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXCLK      (RXCLK),
    .CLEAR      (CLEAR),
    .WLS        (WLS),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .SIN        (SIN),
    .DOUT       (DOUT),
    .PE         (PE),
    .FE         (FE),
    .BI         (BI),
    .RXFINISHED (RXFINISHED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RXFINISHED) begin
      fin_cnt = fin_cnt + 1;
      fin_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; leaves SIN at b for n cycles.
  task automatic drive(input logic b, input int n);
    SIN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic par);
    start_cyc = cyc;
    drive(1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(data[i], 16);
    if (pen) drive(par, 16);
    drive(1'b1, 16);
    drive(1'b1, 8);
  endtask

  task automatic set_cfg(input logic [1:0] wls, input logic pen, input logic eps,
                         input logic sp);
    WLS = wls;
    PEN = pen;
    EPS = eps;
    SP  = sp;
  endtask

  initial begin
    RST   = 1'b1;
    RXCLK = 1'b1;
    CLEAR = 1'b0;
    SIN   = 1'b1;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_dout", 32'(DOUT), 32'h00);
    check("rst_flags", {29'd0, PE, FE, BI}, 32'd0);
    check("rst_fin", 32'(RXFINISHED), 32'd0);
    RST = 1'b0;
    drive(1'b1, 10);

    // 8N1 0xA5
    fin_base = fin_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    check("a5_fin_cnt", 32'(fin_cnt - fin_base), 32'd1);
    check("a5_dout", 32'(DOUT), 32'hA5);
    check("a5_flags", {29'd0, PE, FE, BI}, 32'd0);
    check("a5_latency", 32'(fin_cyc - start_cyc), 32'd153);

    // False start
    fin_base = fin_cnt;
    drive(1'b0, 4);
    drive(1'b1, 30);
    check("false_fin", 32'(fin_cnt - fin_base), 32'd0);
    check("false_idle", 32'(dut.state_q), 32'(StIdle));
    check("false_dout", 32'(DOUT), 32'hA5);

    // 7E1 0x35, parity bit 1 then 0
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1);
    check("7e1_dout_a", 32'(DOUT), 32'h35);
    check("7e1_pe_bad", 32'(PE), 32'd1);
    send_frame(8'h35, 7, 1'b1, 1'b0);
    check("7e1_pe_good", 32'(PE), 32'd0);

    // Stick parity, 6 bits, EPS=1 -> parity bit should be 0
    set_cfg(2'b01, 1'b1, 1'b1, 1'b1);
    send_frame(8'h2A, 6, 1'b1, 1'b1);
    check("stick_dout", 32'(DOUT), 32'h2A);
    check("stick_pe", 32'(PE), 32'd1);

    // 5N1, upper bits must stay zero
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h15, 5, 1'b0, 1'b0);
    check("5n1_dout", 32'(DOUT), 32'h15);

    // Held break
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    fin_base = fin_cnt;
    drive(1'b0, 300);
    drive(1'b1, 16);
    check("brk_fin_cnt", 32'(fin_cnt - fin_base), 32'd1);
    check("brk_dout", 32'(DOUT), 32'h00);
    check("brk_fe_bi", {30'd0, FE, BI}, 32'd3);
    send_frame(8'h5A, 8, 1'b0, 1'b0);
    check("post_brk_dout", 32'(DOUT), 32'h5A);
    check("post_brk_flags", {29'd0, PE, FE, BI}, 32'd0);

    // CLEAR during DATA
    set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
    fin_base = fin_cnt;
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    CLEAR = 1'b1;
    @(posedge CLK);
    #1;
    CLEAR = 1'b0;
    drive(1'b1, 200);
    check("clr_fin", 32'(fin_cnt - fin_base), 32'd0);
    check("clr_dout", 32'(DOUT), 32'h5A);
    check("clr_idle", 32'(dut.state_q), 32'(StIdle));
    send_frame(8'hC3, 8, 1'b1, 1'b1);
    check("clr_next_dout", 32'(DOUT), 32'hC3);
    check("clr_next_pe", 32'(PE), 32'd0);

    // RST during PAR
    fin_base = fin_cnt;
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(i[0] ? 1'b0 : 1'b1, 16);
    drive(1'b1, 8);
    RST = 1'b1;
    #2;
    check("rst_mid_dout", 32'(DOUT), 32'h00);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1'b1, 40);
    check("rst_mid_fin", 32'(fin_cnt - fin_base), 32'd0);
    send_frame(8'hC3, 8, 1'b1, 1'b1);
    check("rst_next_dout", 32'(DOUT), 32'hC3);
    check("rst_next_pe", 32'(PE), 32'd0);

    // WLS changed after start is captured
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    fin_base = fin_cnt;
    drive(1'b0, 16);
    WLS = 2'b00;
    drive(1'b1, 16);
    for (int i = 1; i < 7; i++) drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 24);
    check("wls_fin", 32'(fin_cnt - fin_base), 32'd1);
    check("wls_dout", 32'(DOUT), 32'h81);
    check("wls_fe", 32'(FE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
